// File: rtl/flash_loader_pkg.sv
// flash_loader_pkg: shared state encoding and SPI constants for the boot loader
package flash_loader_pkg;
   typedef enum logic [2:0] {
      POWER_WAIT,
      SEND,
      READ,
      WRITE,
      WAIT_CACHE,
      DONE
   } state_t;
   localparam logic [7:0] FLASH_CMD_READ = 8'h03;
   localparam int SPI_ADDR_BITS = 24;
endpackage

// File: rtl/flash_loader_if.sv
// flash_loader_if: SPI flash pins, cache write port and status of the boot loader
interface flash_loader_if;
   logic        flash_clk;
   logic        flash_mosi;
   logic        flash_miso;
   logic        flash_cs;
   logic [31:0] cache_address;
   logic [31:0] cache_data_in;
   logic [3:0]  cache_write_enable;
   logic        cache_busy;
   logic        busy;
   logic        done;
   modport master (
      output flash_clk, flash_mosi, flash_cs, cache_address, cache_data_in,
             cache_write_enable, busy, done,
      input  flash_miso, cache_busy
   );
   modport slave (
      input  flash_clk, flash_mosi, flash_cs, cache_address, cache_data_in,
             cache_write_enable, busy, done,
      output flash_miso, cache_busy
   );
endinterface

// File: rtl/flash_loader_spi_bit_engine.sv
// flash_loader_spi_bit_engine: two-phase clk/2 SPI serializer (send mode) / deserializer (receive mode)
module flash_loader_spi_bit_engine (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_send,
   input  logic [31:0] i_tx,
   input  logic [5:0]  i_bits,
   input  logic        i_miso,
   output logic        o_clk,
   output logic        o_mosi,
   output logic [7:0]  o_rx_byte,
   output logic        o_byte_valid,
   output logic        o_last,
   output logic        o_idle
);
   logic        r_active;
   logic        r_phase;
   logic        r_send;
   logic [5:0]  r_cnt;
   logic [31:0] r_sh;
   logic [6:0]  r_rx;
   logic [2:0]  r_bit;
   logic        w_p0;
   logic        w_p1;

   assign w_p0         = r_active && !r_phase;
   assign w_p1         = r_active && r_phase;
   assign o_last       = w_p1 && (r_cnt == 6'd0);
   assign o_byte_valid = w_p1 && !r_send && (r_bit == 3'd7);
   assign o_rx_byte    = {r_rx, i_miso};
   assign o_idle       = !r_active;

   // bit-cell sequencing: a load may coincide with the final phase 1 of the previous transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_active <= 1'b0;
         r_phase  <= 1'b0;
         r_send   <= 1'b0;
         r_cnt    <= 6'd0;
         r_sh     <= 32'd0;
         r_bit    <= 3'd0;
      end else if (i_load) begin
         r_active <= 1'b1;
         r_phase  <= 1'b0;
         r_send   <= i_send;
         r_cnt    <= i_bits;
         r_sh     <= i_tx;
         r_bit    <= 3'd0;
      end else if (r_active) begin
         r_phase <= !r_phase;
         if (o_last) r_active <= 1'b0;
         if (w_p0) r_cnt <= r_cnt - 6'd1;
         if (w_p0 && r_send) r_sh <= {r_sh[30:0], 1'b0};
         if (w_p1 && !r_send) r_bit <= r_bit + 3'd1;
      end
   end

   // pin drivers: clock high only in phase 1, MOSI updates in phase 0, MISO sampled in phase 1
   always_ff @(posedge clk) begin
      if (rst) begin
         o_clk  <= 1'b0;
         o_mosi <= 1'b0;
         r_rx   <= 7'd0;
      end else begin
         o_clk <= w_p1;
         if (w_p0 && r_send) o_mosi <= r_sh[31];
         if (w_p1 && !r_send) r_rx <= {r_rx[5:0], i_miso};
      end
   end
endmodule

// File: rtl/flash_loader.sv
// flash_loader: copies a flash region into the cache as little-endian words after a power-up wait
module flash_loader
   import flash_loader_pkg::*;
#(
   parameter int unsigned                 STARTUP_WAIT   = 1_000_000,
   parameter logic [SPI_ADDR_BITS-1:0]    FLASH_ADDRESS  = 24'h00_0000,
   parameter logic [31:0]                 CACHE_ADDRESS  = 32'h0000_0000,
   parameter logic [31:0]                 TRANSFER_BYTES = 32'h0000_0010
) (
   input  logic           clk,
   input  logic           rst,
   flash_loader_if.master bus
);
   localparam logic [31:0] WAIT_LAST = STARTUP_WAIT - 1;
   localparam logic [31:0] N_WORDS   = TRANSFER_BYTES >> 2;

   generate
      if (TRANSFER_BYTES[1:0] != 2'b00 || TRANSFER_BYTES < 32'd4 || STARTUP_WAIT < 1) begin : g_bad_params
         $error("flash_loader: TRANSFER_BYTES must be a multiple of 4 and >= 4, STARTUP_WAIT >= 1");
      end
   endgenerate

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_cnt;
   logic [31:0] r_dest;
   logic [31:0] r_words;
   logic [31:0] r_word;
   logic [1:0]  r_byte_ix;
   logic        w_load;
   logic        w_send;
   logic        w_last;
   logic        w_byte_valid;
   logic        w_idle;
   logic [7:0]  w_rx_byte;

   assign w_load = ((w_next == SEND) && (r_state != SEND)) || ((w_next == READ) && (r_state != READ));
   assign w_send = (w_next == SEND);

   flash_loader_spi_bit_engine u_spi (
      .clk          (clk),
      .rst          (rst),
      .i_load       (w_load),
      .i_send       (w_send),
      .i_tx         ({FLASH_CMD_READ, FLASH_ADDRESS}),
      .i_bits       (6'd32),
      .i_miso       (bus.flash_miso),
      .o_clk        (bus.flash_clk),
      .o_mosi       (bus.flash_mosi),
      .o_rx_byte    (w_rx_byte),
      .o_byte_valid (w_byte_valid),
      .o_last       (w_last),
      .o_idle       (w_idle)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= POWER_WAIT;
      else     r_state <= w_next;
   end

   // next state: each READ pass fetches exactly one 32-bit word, then the cache handshake runs
   always_comb begin
      w_next = r_state;
      case (r_state)
         POWER_WAIT: w_next = (r_cnt == WAIT_LAST) ? SEND : POWER_WAIT;
         SEND:       w_next = w_last ? READ : SEND;
         READ:       w_next = w_last ? WRITE : READ;
         WRITE:      w_next = WAIT_CACHE;
         WAIT_CACHE: w_next = (bus.cache_busy || !w_idle) ? WAIT_CACHE :
                              (r_words == N_WORDS) ? DONE : READ;
         default:    w_next = DONE;
      endcase
   end

   // outputs decoded from state: chip select stays low across cache stalls so the read stream continues
   always_comb begin
      bus.flash_cs           = (r_state == POWER_WAIT) || (r_state == DONE);
      bus.cache_write_enable = (r_state == WAIT_CACHE) ? 4'b1111 : 4'b0000;
      bus.busy               = (r_state != DONE);
      bus.done               = (r_state == DONE);
   end

   // datapath: startup counter, byte packing into lanes, cache request registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt             <= 32'd0;
         r_dest            <= CACHE_ADDRESS;
         r_words           <= 32'd0;
         r_word            <= 32'd0;
         r_byte_ix         <= 2'd0;
         bus.cache_address <= 32'd0;
         bus.cache_data_in <= 32'd0;
      end else begin
         if (r_state == POWER_WAIT) r_cnt <= r_cnt + 32'd1;
         if (w_byte_valid) begin
            r_word[{r_byte_ix, 3'b000} +: 8] <= w_rx_byte;
            r_byte_ix                        <= r_byte_ix + 2'd1;
         end
         if (r_state == WRITE) begin
            bus.cache_address <= r_dest;
            bus.cache_data_in <= r_word;
            r_dest            <= r_dest + 32'd4;
            r_words           <= r_words + 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: directed bench with a SPI flash model and a cache model for flash_loader
module tb_flash_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   errors = 0;

   flash_loader_if bus ();

   flash_loader #(
      .STARTUP_WAIT   (10),
      .FLASH_ADDRESS  (24'h123456),
      .CACHE_ADDRESS  (32'hFFFF_FFF8),
      .TRANSFER_BYTES (32'h0000_0010)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   logic [31:0] exp_addr [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
   logic [31:0] exp_data [4] = '{32'h3433_3231, 32'h3837_3635, 32'h3C3B_3A39, 32'h403F_3E3D};

   logic [31:0] m_cmd = 32'd0;
   int          m_bits = 0;
   int          m_dbit = 0;
   logic        m_pclk = 1'b0;
   logic        m_miso = 1'b0;
   logic [7:0]  m_byte = 8'd0;
   logic        n_miso = 1'b0;
   logic        n_busy = 1'b0;
   logic        m_busy = 1'b0;
   int          hold = 0;
   int          busy_cnt = 0;
   logic [31:0] wr_addr [64];
   logic [31:0] wr_data [64];
   int          wr_n = 0;

   assign bus.flash_miso = m_miso ^ n_miso;
   assign bus.cache_busy = m_busy | n_busy;

   // flash: captures command on rising SPI clock, shifts out 0x31,0x32,... on falling clock
   always @(bus.flash_cs or bus.flash_clk) begin
      if (bus.flash_cs !== 1'b0) begin
         m_bits = 0;
         m_cmd  = 32'd0;
         m_dbit = 0;
         m_miso = 1'b0;
      end else if (bus.flash_clk === 1'b1 && !m_pclk) begin
         if (m_bits < 32) begin
            m_cmd  = {m_cmd[30:0], bus.flash_mosi};
            m_bits = m_bits + 1;
         end
      end else if (bus.flash_clk === 1'b0 && m_pclk && m_bits >= 32) begin
         m_byte = 8'(8'h31 + m_dbit / 8);
         m_miso = m_byte[7 - (m_dbit % 8)];
         m_dbit = m_dbit + 1;
      end
      m_pclk = (bus.flash_clk === 1'b1);
   end

   // cache: holds busy for 'hold' cycles after write_enable rises
   always @(negedge clk) begin
      if (bus.cache_write_enable == 4'hF) begin
         if (busy_cnt < hold) begin
            m_busy   <= 1'b1;
            busy_cnt <= busy_cnt + 1;
         end else m_busy <= 1'b0;
      end else begin
         busy_cnt <= 0;
         m_busy   <= 1'b0;
      end
   end

   // cache: logs each accepted write
   always @(posedge clk) begin
      if (bus.cache_write_enable == 4'hF && !bus.cache_busy && wr_n < 64) begin
         wr_addr[wr_n] <= bus.cache_address;
         wr_data[wr_n] <= bus.cache_data_in;
         wr_n          <= wr_n + 1;
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      hold = 0;
      repeat (3) @(negedge clk);
      vectors += 8;
      if (bus.flash_clk !== 1'b0) begin errors++; $display("FAIL reset_flash_clk got %b want 0", bus.flash_clk); end
      if (bus.flash_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", bus.flash_mosi); end
      if (bus.flash_cs !== 1'b1) begin errors++; $display("FAIL reset_cs got %b want 1", bus.flash_cs); end
      if (bus.cache_address !== 32'd0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.cache_address); end
      if (bus.cache_data_in !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", bus.cache_data_in); end
      if (bus.cache_write_enable !== 4'd0) begin errors++; $display("FAIL reset_we got %h want 0", bus.cache_write_enable); end
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", bus.busy); end
      if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
   endtask

   task automatic test_startup();
      int first_cs = 0;
      int first_clk = 0;
      rst = 1'b0;
      for (int i = 1; i <= 40 && first_clk == 0; i++) begin
         @(negedge clk);
         if (first_cs == 0 && bus.flash_cs === 1'b0) first_cs = i;
         if (first_clk == 0 && bus.flash_clk === 1'b1) first_clk = i;
      end
      vectors += 2;
      if (first_cs != 10) begin errors++; $display("FAIL startup_cs_cycle got %0d want 10", first_cs); end
      if (first_clk != 12) begin errors++; $display("FAIL startup_clk_cycle got %0d want 12", first_clk); end
      for (int i = 0; i < 100 && m_bits < 32; i++) @(negedge clk);
      vectors += 4;
      if (m_cmd[31:24] !== 8'h03) begin errors++; $display("FAIL cmd_byte got %h want 03", m_cmd[31:24]); end
      if (m_cmd[23:16] !== 8'h12) begin errors++; $display("FAIL addr_hi got %h want 12", m_cmd[23:16]); end
      if (m_cmd[15:8] !== 8'h34) begin errors++; $display("FAIL addr_mid got %h want 34", m_cmd[15:8]); end
      if (m_cmd[7:0] !== 8'h56) begin errors++; $display("FAIL addr_lo got %h want 56", m_cmd[7:0]); end
   endtask

   task automatic test_basic();
      int run = 0;
      int cyc = 0;
      int base = wr_n;
      while (bus.done !== 1'b1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         if (bus.cache_write_enable === 4'hF) run++;
         else if (run != 0) begin
            vectors++;
            if (run != 1) begin errors++; $display("FAIL basic_we_len got %0d want 1", run); end
            run = 0;
         end
      end
      vectors += 4;
      if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", bus.done); end
      if (bus.flash_cs !== 1'b1) begin errors++; $display("FAIL basic_cs got %b want 1", bus.flash_cs); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", bus.busy); end
      if (wr_n - base != 4) begin errors++; $display("FAIL basic_count got %0d want 4", wr_n - base); end
      for (int k = 0; k < 4; k++) begin
         vectors += 2;
         if (wr_addr[base + k] !== exp_addr[k]) begin errors++; $display("FAIL basic_addr%0d got %h want %h", k, wr_addr[base + k], exp_addr[k]); end
         if (wr_data[base + k] !== exp_data[k]) begin errors++; $display("FAIL basic_data%0d got %h want %h", k, wr_data[base + k], exp_data[k]); end
      end
   endtask

   task automatic test_busy();
      int run = 0;
      int cyc = 0;
      int base;
      logic clk_bad = 1'b0;
      rst = 1'b1;
      hold = 5;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      base = wr_n;
      while (bus.done !== 1'b1 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (bus.cache_write_enable === 4'hF) begin
            run++;
            if (bus.flash_clk !== 1'b0) clk_bad = 1'b1;
         end else if (run != 0) begin
            vectors += 2;
            if (run != 6) begin errors++; $display("FAIL busy_we_len got %0d want 6", run); end
            if (clk_bad) begin errors++; $display("FAIL busy_flash_clk got 1 want 0"); end
            run = 0;
            clk_bad = 1'b0;
         end
      end
      vectors += 2;
      if (bus.done !== 1'b1) begin errors++; $display("FAIL busy_done got %b want 1", bus.done); end
      if (wr_n - base != 4) begin errors++; $display("FAIL busy_count got %0d want 4", wr_n - base); end
      for (int k = 0; k < 4; k++) begin
         vectors += 2;
         if (wr_addr[base + k] !== exp_addr[k]) begin errors++; $display("FAIL busy_addr%0d got %h want %h", k, wr_addr[base + k], exp_addr[k]); end
         if (wr_data[base + k] !== exp_data[k]) begin errors++; $display("FAIL busy_data%0d got %h want %h", k, wr_data[base + k], exp_data[k]); end
      end
      hold = 0;
   endtask

   task automatic test_reset_mid();
      int base;
      int base2;
      int cyc = 0;
      rst = 1'b1;
      hold = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      base = wr_n;
      while (wr_n - base < 2 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      repeat (20) @(negedge clk);
      vectors++;
      if (wr_n - base != 2) begin errors++; $display("FAIL mid_pre_count got %0d want 2", wr_n - base); end
      rst = 1'b1;
      @(negedge clk);
      vectors += 3;
      if (bus.flash_cs !== 1'b1) begin errors++; $display("FAIL mid_cs got %b want 1", bus.flash_cs); end
      if (bus.cache_write_enable !== 4'd0) begin errors++; $display("FAIL mid_we got %h want 0", bus.cache_write_enable); end
      if (bus.flash_clk !== 1'b0) begin errors++; $display("FAIL mid_flash_clk got %b want 0", bus.flash_clk); end
      rst = 1'b0;
      base2 = wr_n;
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      vectors += 6;
      if (bus.done !== 1'b1) begin errors++; $display("FAIL mid_done got %b want 1", bus.done); end
      if (wr_n - base2 != 4) begin errors++; $display("FAIL mid_count got %0d want 4", wr_n - base2); end
      if (wr_addr[base2] !== exp_addr[0]) begin errors++; $display("FAIL mid_addr0 got %h want %h", wr_addr[base2], exp_addr[0]); end
      if (wr_data[base2] !== exp_data[0]) begin errors++; $display("FAIL mid_data0 got %h want %h", wr_data[base2], exp_data[0]); end
      if (wr_addr[base2 + 3] !== exp_addr[3]) begin errors++; $display("FAIL mid_addr3 got %h want %h", wr_addr[base2 + 3], exp_addr[3]); end
      if (wr_data[base2 + 3] !== exp_data[3]) begin errors++; $display("FAIL mid_data3 got %h want %h", wr_data[base2 + 3], exp_data[3]); end
   endtask

   task automatic test_after_done();
      int base = wr_n;
      int bad_cs = 0;
      int bad_done = 0;
      int bad_we = 0;
      repeat (1000) begin
         n_miso = 1'($urandom);
         n_busy = 1'($urandom);
         @(negedge clk);
         if (bus.flash_cs !== 1'b1) bad_cs++;
         if (bus.done !== 1'b1) bad_done++;
         if (bus.cache_write_enable !== 4'd0) bad_we++;
      end
      n_miso = 1'b0;
      n_busy = 1'b0;
      @(negedge clk);
      vectors += 4;
      if (wr_n != base) begin errors++; $display("FAIL idle_writes got %0d want 0", wr_n - base); end
      if (bad_cs != 0) begin errors++; $display("FAIL idle_cs got %0d bad cycles want 0", bad_cs); end
      if (bad_done != 0) begin errors++; $display("FAIL idle_done got %0d bad cycles want 0", bad_done); end
      if (bad_we != 0) begin errors++; $display("FAIL idle_we got %0d bad cycles want 0", bad_we); end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_basic();
      test_busy();
      test_reset_mid();
      test_after_done();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
